// File: rtl/apb_fll_mc_pkg.sv
// Shared types and constants for the multi-channel APB-to-FLL configuration bridge.
package apb_fll_mc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StErr,
        StWaitLow
    } fll_state_e;

    localparam logic [5:0] LOCK_STATUS_IDX = 6'd48;
    localparam logic [5:0] LOCK_LOST_IDX   = 6'd49;
    localparam logic [5:0] TIMEOUT_CFG_IDX = 6'd50;

    localparam int unsigned TIMEOUT_W = 16;

endpackage

// File: rtl/apb_fll_mc_if_if.sv
// APB slave-side bus bundle for the FLL configuration bridge.
interface apb_fll_mc_if_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_fll_mc_sync.sv
// Multi-bit flop synchroniser; each bit is an independent level, no bus coherency implied.
module apb_fll_mc_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/apb_fll_mc_if.sv
// APB slave fanning out to NUM_FLL FLL config ports over a four-phase req/ack handshake,
// with lock monitoring, sticky loss-of-lock flags and a programmable handshake timeout.
module apb_fll_mc_if
    import apb_fll_mc_pkg::*;
#(
    parameter int unsigned NUM_FLL         = 4,
    parameter int unsigned APB_ADDR_WIDTH  = 12,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned TIMEOUT_DEFAULT = 1024
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    apb_fll_mc_if_if.slave          apb,
    output logic [NUM_FLL-1:0]      fll_req_o,
    output logic                    fll_wrn_o,
    output logic [1:0]              fll_add_o,
    output logic [31:0]             fll_data_o,
    input  logic [NUM_FLL-1:0]      fll_ack_i,
    input  logic [32*NUM_FLL-1:0]   fll_r_data_i,
    input  logic [NUM_FLL-1:0]      fll_lock_i
);

    localparam logic [5:0]           ChanWords  = 6'(4 * NUM_FLL);
    localparam logic [TIMEOUT_W-1:0] TimeoutRst = TIMEOUT_W'(TIMEOUT_DEFAULT);

    fll_state_e             state_q, state_d;
    logic [NUM_FLL-1:0]     req_q, req_d;
    logic [NUM_FLL-1:0]     sel_q, sel_d;
    logic                   wrn_q, wrn_d;
    logic [1:0]             add_q, add_d;
    logic [31:0]            data_q, data_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]   tmo_cfg_q, tmo_cfg_d;
    logic [31:0]            prdata_q, prdata_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [NUM_FLL-1:0]     lock_lost_q, lock_lost_d;
    logic [NUM_FLL-1:0]     lock_prev_q, lock_prev_d;

    logic [NUM_FLL-1:0]     ack_sync, lock_sync;
    logic [NUM_FLL-1:0]     hit_sel;
    logic [31:0]            rdata_c, local_rdata;
    logic [5:0]             word;
    logic                   access, chan_hit, local_hit, local_acc, local_wr, ack_c;
    logic                   unused_paddr;

    apb_fll_mc_sync #(
        .WIDTH       (NUM_FLL),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (HCLK),
        .rst_i (HRESET),
        .d_i   (fll_ack_i),
        .q_o   (ack_sync)
    );

    apb_fll_mc_sync #(
        .WIDTH       (NUM_FLL),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (HCLK),
        .rst_i (HRESET),
        .d_i   (fll_lock_i),
        .q_o   (lock_sync)
    );

    assign word         = apb.PADDR[7:2];
    assign unused_paddr = ^{apb.PADDR[APB_ADDR_WIDTH-1:8], apb.PADDR[1:0]};
    assign access       = apb.PSEL & apb.PENABLE;
    assign chan_hit     = (word < ChanWords);
    assign local_hit    = (word == LOCK_STATUS_IDX) | (word == LOCK_LOST_IDX) |
                          (word == TIMEOUT_CFG_IDX);
    // Everything that is not a channel word completes in the access phase, including errors.
    assign local_acc    = access & ~chan_hit;
    assign local_wr     = local_acc & apb.PWRITE;
    assign ack_c        = |(ack_sync & sel_q);

    always_comb begin
        hit_sel = '0;
        rdata_c = '0;
        for (int unsigned c = 0; c < NUM_FLL; c++) begin
            hit_sel[c] = (word[5:2] == 4'(c));
            if (sel_q[c]) begin
                rdata_c = rdata_c | fll_r_data_i[32*c +: 32];
            end
        end
    end

    always_comb begin
        local_rdata = '0;
        case (word)
            LOCK_STATUS_IDX: local_rdata = 32'(lock_sync);
            LOCK_LOST_IDX:   local_rdata = 32'(lock_lost_q);
            TIMEOUT_CFG_IDX: local_rdata = 32'(tmo_cfg_q);
            default:         local_rdata = '0;
        endcase
    end

    always_comb begin
        lock_prev_d = lock_sync;
        tmo_cfg_d   = tmo_cfg_q;
        lock_lost_d = lock_lost_q;
        if (local_wr && word == TIMEOUT_CFG_IDX) begin
            tmo_cfg_d = apb.PWDATA[TIMEOUT_W-1:0];
        end
        if (local_wr && word == LOCK_LOST_IDX) begin
            lock_lost_d = lock_lost_d & ~apb.PWDATA[NUM_FLL-1:0];
        end
        // Applied after the clear so a coincident falling lock edge is never lost.
        lock_lost_d = lock_lost_d | (lock_prev_q & ~lock_sync);
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sel_d     = sel_q;
        wrn_d     = wrn_q;
        add_d     = add_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (access && chan_hit) begin
                    sel_d   = hit_sel;
                    req_d   = hit_sel;
                    wrn_d   = ~apb.PWRITE;
                    add_d   = apb.PADDR[3:2];
                    data_d  = apb.PWDATA;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (ack_c) begin
                    prdata_d = wrn_q ? rdata_c : '0;
                    pready_d = 1'b1;
                    req_d    = '0;
                    state_d  = StResp;
                end else if (tmo_cfg_q != '0 && cnt_q == tmo_cfg_q - TIMEOUT_W'(1)) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    req_d     = '0;
                    state_d   = StErr;
                end
            end
            StResp, StErr: begin
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!ack_c) begin
                    sel_d   = '0;
                    wrn_d   = 1'b1;
                    add_d   = '0;
                    data_d  = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            req_q       <= '0;
            sel_q       <= '0;
            wrn_q       <= 1'b1;
            add_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            tmo_cfg_q   <= TimeoutRst;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            lock_lost_q <= '0;
            lock_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            sel_q       <= sel_d;
            wrn_q       <= wrn_d;
            add_q       <= add_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            tmo_cfg_q   <= tmo_cfg_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            lock_lost_q <= lock_lost_d;
            lock_prev_q <= lock_prev_d;
        end
    end

    assign fll_req_o   = req_q;
    assign fll_wrn_o   = wrn_q;
    assign fll_add_o   = add_q;
    assign fll_data_o  = data_q;

    assign apb.PREADY  = local_acc ? 1'b1       : pready_q;
    assign apb.PSLVERR = local_acc ? ~local_hit : pslverr_q;
    assign apb.PRDATA  = local_acc ? local_rdata : prdata_q;

endmodule
